// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared core constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM = 32;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: busy bits for registers awaiting a divider writeback.
module pipe_scoreboard import pipe_ctrl_pkg::*; (
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t rd1_addr,
    input  reg_addr_t rd2_addr,
    output logic      rd1_busy,
    output logic      rd2_busy,
    output logic      any_busy
);
    logic [REG_NUM-1:0] busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            // Set is applied last so a same-cycle start wins over a done.
            if (set_en && set_addr != ZERO_REG) busy[set_addr] <= 1'b1;
        end
    end

    assign rd1_busy = busy[rd1_addr];
    assign rd2_busy = busy[rd2_addr];
    assign any_busy = |busy;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, stall and redirect control for the IF -> ID -> EX pipeline.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter int STALL_MAX = 15,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  reg_addr_t   id_reg1_addr_i,
    input  reg_addr_t   id_reg2_addr_i,
    input  logic        id_reg1_rd_i,
    input  logic        id_reg2_rd_i,
    input  logic        id_is_div_i,
    input  logic        ex_wr_en_i,
    input  reg_addr_t   ex_wr_addr_i,
    input  logic        ex_is_load_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        div_start_i,
    input  reg_addr_t   div_rd_i,
    input  logic        div_done_i,
    input  reg_addr_t   div_done_rd_i,
    input  logic        mem_busy_i,
    output logic        hold_pc_o,
    output logic        hold_ifid_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        pc_jump_o,
    output logic [31:0] pc_jump_addr_o,
    output logic        stall_timeout_o
);
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);

    logic             jump_pend, timeout;
    logic [31:0]      jump_addr;
    logic [CNT_W-1:0] stall_cnt, cnt_nxt;
    logic             src1, src2, load_use, sb_hit, div_struct, rd1_busy, rd2_busy, any_busy;

    pipe_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (div_start_i),
        .set_addr (div_rd_i),
        .clr_en   (div_done_i),
        .clr_addr (div_done_rd_i),
        .rd1_addr (id_reg1_addr_i),
        .rd2_addr (id_reg2_addr_i),
        .rd1_busy (rd1_busy),
        .rd2_busy (rd2_busy),
        .any_busy (any_busy)
    );

    assign src1 = id_reg1_rd_i && id_reg1_addr_i != ZERO_REG;
    assign src2 = id_reg2_rd_i && id_reg2_addr_i != ZERO_REG;
    assign load_use = ex_is_load_i && ex_wr_en_i && ex_wr_addr_i != ZERO_REG &&
                      ((src1 && ex_wr_addr_i == id_reg1_addr_i) || (src2 && ex_wr_addr_i == id_reg2_addr_i));
    assign sb_hit = (src1 && rd1_busy) || (src2 && rd2_busy);
    assign div_struct = id_is_div_i && any_busy;

    always_comb begin
        hold_pc_o = 1'b0;
        hold_ifid_o = 1'b0;
        flush_ifid_o = 1'b0;
        flush_idex_o = 1'b0;
        pc_jump_o = 1'b0;
        pc_jump_addr_o = '0;
        if (rst) begin
            flush_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
        end else if (mem_busy_i) begin
            hold_pc_o = 1'b1;
            hold_ifid_o = 1'b1;
        end else if (jump_pend || ex_jump_i) begin
            pc_jump_o = 1'b1;
            flush_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
            pc_jump_addr_o = jump_pend ? jump_addr : ex_jump_addr_i;
        end else if (load_use || sb_hit || div_struct) begin
            hold_pc_o = 1'b1;
            hold_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
        end
    end

    assign cnt_nxt = !hold_pc_o ? '0 : (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    assign stall_timeout_o = timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            jump_pend <= 1'b0;
            jump_addr <= '0;
            stall_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            // A jump seen during a bus freeze is parked and replayed once the bus frees.
            if (mem_busy_i && ex_jump_i) begin
                jump_pend <= 1'b1;
                jump_addr <= ex_jump_addr_i;
            end else if (!mem_busy_i) begin
                jump_pend <= 1'b0;
            end
            stall_cnt <= cnt_nxt;
            timeout <= timeout || cnt_nxt >= STALL_LIM;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for the pipeline hazard controller.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_reg1_addr, id_reg2_addr, ex_wr_addr, div_rd, div_done_rd;
    logic        id_reg1_rd, id_reg2_rd, id_is_div, ex_wr_en, ex_is_load, ex_jump;
    logic        div_start, div_done, mem_busy;
    logic [31:0] ex_jump_addr;
    logic        hold_pc, hold_ifid, flush_ifid, flush_idex, pc_jump, stall_timeout;
    logic [31:0] pc_jump_addr;
    logic [4:0]  ctl;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_reg1_addr_i  (id_reg1_addr),
        .id_reg2_addr_i  (id_reg2_addr),
        .id_reg1_rd_i    (id_reg1_rd),
        .id_reg2_rd_i    (id_reg2_rd),
        .id_is_div_i     (id_is_div),
        .ex_wr_en_i      (ex_wr_en),
        .ex_wr_addr_i    (ex_wr_addr),
        .ex_is_load_i    (ex_is_load),
        .ex_jump_i       (ex_jump),
        .ex_jump_addr_i  (ex_jump_addr),
        .div_start_i     (div_start),
        .div_rd_i        (div_rd),
        .div_done_i      (div_done),
        .div_done_rd_i   (div_done_rd),
        .mem_busy_i      (mem_busy),
        .hold_pc_o       (hold_pc),
        .hold_ifid_o     (hold_ifid),
        .flush_ifid_o    (flush_ifid),
        .flush_idex_o    (flush_idex),
        .pc_jump_o       (pc_jump),
        .pc_jump_addr_o  (pc_jump_addr),
        .stall_timeout_o (stall_timeout)
    );

    // ctl bit order: hold_pc, hold_ifid, flush_ifid, flush_idex, pc_jump
    assign ctl = {hold_pc, hold_ifid, flush_ifid, flush_idex, pc_jump};

    task automatic clear_in();
        id_reg1_addr = 0; id_reg2_addr = 0; id_reg1_rd = 0; id_reg2_rd = 0; id_is_div = 0;
        ex_wr_en = 0; ex_wr_addr = 0; ex_is_load = 0; ex_jump = 0; ex_jump_addr = 0;
        div_start = 0; div_rd = 0; div_done = 0; div_done_rd = 0; mem_busy = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; clear_in();
        @(negedge clk);
        total++; if (ctl !== 5'b00110) $display("FAIL rst_ctl got=%b exp=%b", ctl, 5'b00110); else passed++;
        total++; if (pc_jump_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=%h", pc_jump_addr, 32'h0); else passed++;
        total++; if (stall_timeout !== 1'b0) $display("FAIL rst_timeout got=%b exp=0", stall_timeout); else passed++;
        tick(); rst = 0;
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL post_rst_ctl got=%b exp=%b", ctl, 5'b00000); else passed++;
    endtask

    task automatic test_load_use();
        tick();
        ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 5; id_reg1_rd = 1; id_reg1_addr = 5;
        @(negedge clk);
        total++; if (ctl !== 5'b11010) $display("FAIL load_use got=%b exp=%b", ctl, 5'b11010); else passed++;
        tick(); ex_is_load = 0; ex_wr_en = 0; ex_wr_addr = 0;
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL load_use_bubble got=%b exp=%b", ctl, 5'b00000); else passed++;
        tick(); ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 5; id_reg1_rd = 0;
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL load_use_noread got=%b exp=%b", ctl, 5'b00000); else passed++;
        tick(); ex_wr_addr = 0; id_reg1_rd = 1; id_reg1_addr = 0;
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL load_use_x0 got=%b exp=%b", ctl, 5'b00000); else passed++;
        tick(); clear_in();
    endtask

    task automatic test_div();
        div_start = 1; div_rd = 7; id_reg2_rd = 1; id_reg2_addr = 7;
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL div_start_cycle got=%b exp=%b", ctl, 5'b00000); else passed++;
        tick(); div_start = 0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin div_done = 1; div_done_rd = 7; end
            @(negedge clk);
            total++; if (ctl !== 5'b11010) $display("FAIL div_stall_%0d got=%b exp=%b", i, ctl, 5'b11010); else passed++;
            tick();
        end
        div_done = 0;
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL div_release got=%b exp=%b", ctl, 5'b00000); else passed++;
        tick(); clear_in(); div_start = 1; div_rd = 0;
        tick(); div_start = 0; id_is_div = 1;
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL div_rd_x0 got=%b exp=%b", ctl, 5'b00000); else passed++;
        id_is_div = 0; div_start = 1; div_rd = 12;
        tick(); div_start = 0; id_is_div = 1;
        @(negedge clk);
        total++; if (ctl !== 5'b11010) $display("FAIL div_struct got=%b exp=%b", ctl, 5'b11010); else passed++;
        div_done = 1; div_done_rd = 12;
        tick(); clear_in();
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL div_struct_release got=%b exp=%b", ctl, 5'b00000); else passed++;
        tick();
    endtask

    task automatic test_jump_busy();
        mem_busy = 1; ex_jump = 1; ex_jump_addr = 32'h00000480;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ctl !== 5'b11000 || pc_jump_addr !== 32'h0) $display("FAIL jb_busy_%0d got=%b/%h exp=%b/%h", i, ctl, pc_jump_addr, 5'b11000, 32'h0); else passed++;
            tick(); ex_jump = 0; ex_jump_addr = 0;
        end
        mem_busy = 0;
        @(negedge clk);
        total++; if (ctl !== 5'b00111 || pc_jump_addr !== 32'h00000480) $display("FAIL jb_replay got=%b/%h exp=%b/%h", ctl, pc_jump_addr, 5'b00111, 32'h480); else passed++;
        tick();
        @(negedge clk);
        total++; if (ctl !== 5'b00000) $display("FAIL jb_after got=%b exp=%b", ctl, 5'b00000); else passed++;
        mem_busy = 1; ex_jump = 1; ex_jump_addr = 32'h00000480;
        tick(); ex_jump_addr = 32'h00000500;
        tick(); ex_jump = 0; ex_jump_addr = 0; mem_busy = 0;
        @(negedge clk);
        total++; if (pc_jump !== 1'b1 || pc_jump_addr !== 32'h00000500) $display("FAIL jb_overwrite got=%b/%h exp=1/%h", pc_jump, pc_jump_addr, 32'h500); else passed++;
        tick();
    endtask

    task automatic test_priority();
        ex_jump = 1; ex_jump_addr = 32'h00000100;
        ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 3; id_reg1_rd = 1; id_reg1_addr = 3;
        @(negedge clk);
        total++; if (ctl !== 5'b00111 || pc_jump_addr !== 32'h00000100) $display("FAIL prio got=%b/%h exp=%b/%h", ctl, pc_jump_addr, 5'b00111, 32'h100); else passed++;
        tick(); clear_in();
        @(negedge clk);
        total++; if (pc_jump_addr !== 32'h0) $display("FAIL prio_addr_idle got=%h exp=%h", pc_jump_addr, 32'h0); else passed++;
        tick();
    endtask

    task automatic test_watchdog();
        div_start = 1; div_rd = 9;
        tick(); div_start = 0; id_reg1_rd = 1; id_reg1_addr = 9;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            total++; if (stall_timeout !== (k == 16)) $display("FAIL wd_cycle_%0d got=%b exp=%b", k, stall_timeout, k == 16); else passed++;
            tick();
        end
        div_done = 1; div_done_rd = 9;
        tick(); clear_in();
        @(negedge clk);
        total++; if (ctl !== 5'b00000 || stall_timeout !== 1'b1) $display("FAIL wd_sticky got=%b/%b exp=%b/1", ctl, stall_timeout, 5'b00000); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        div_start = 1; div_rd = 9;
        tick(); div_start = 0; mem_busy = 1; ex_jump = 1; ex_jump_addr = 32'h00000600;
        tick(); clear_in(); rst = 1;
        @(negedge clk);
        total++; if (ctl !== 5'b00110 || pc_jump_addr !== 32'h0) $display("FAIL rstmid_ctl got=%b/%h exp=%b/%h", ctl, pc_jump_addr, 5'b00110, 32'h0); else passed++;
        tick(); rst = 0; id_reg1_rd = 1; id_reg1_addr = 9;
        @(negedge clk);
        total++; if (ctl !== 5'b00000 || pc_jump_addr !== 32'h0) $display("FAIL rstmid_after got=%b/%h exp=%b/%h", ctl, pc_jump_addr, 5'b00000, 32'h0); else passed++;
        total++; if (stall_timeout !== 1'b0) $display("FAIL rstmid_timeout got=%b exp=0", stall_timeout); else passed++;
        tick(); clear_in();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_div();
        test_jump_busy();
        test_priority();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
